hwpf_issue_ctrl: RTL and testbench
==================================

HWPF_ISSUE_CTRL -- requirements
Module: hwpf_issue_ctrl

Interface
REQ-001 SHALL have parameter NUM_HW_PREFETCH, default 4, number of prefetchers sharing one HPDcache port; request tid selects the prefetcher.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8, global cap on outstanding prefetch requests.
REQ-003 SHALL have parameter MAX_PER_HWPF, default 4, per-prefetcher cap on outstanding requests.
REQ-004 SHALL have parameter STALL_THRESH, default 8, consecutive stalled cycles that trigger backoff.
REQ-005 SHALL have parameter BACKOFF_CYCLES, default 16, length of the backoff window.
REQ-006 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports arb_req_valid_i / arb_req_ready_o / arb_req_i: in / out / in, 1 / 1 / hpdcache_req_t, upstream request from the prefetch arbiter.
REQ-009 SHALL have ports hpdcache_req_valid_o / hpdcache_req_ready_i / hpdcache_req_o: out / in / out, 1 / 1 / hpdcache_req_t, downstream cache request.
REQ-010 SHALL have ports hpdcache_rsp_valid_i / hpdcache_rsp_i: in / in, 1 / hpdcache_rsp_t, observed cache responses.
REQ-011 SHALL have port demand_busy_i, input, 1, core demand traffic pending; prefetch issue is blocked while high.
REQ-012 SHALL have port inflight_o, output, $clog2(MAX_INFLIGHT+1), current global outstanding count.
REQ-013 SHALL have port backoff_o, output, 1, high while in BACKOFF.
REQ-014 SHALL have port err_o, output, 1, sticky protocol error flag.

Function
REQ-015 Request path SHALL be combinational with no added latency: hpdcache_req_o = arb_req_i; hpdcache_req_valid_o = arb_req_valid_i & issue_ok; arb_req_ready_o = hpdcache_req_ready_i & issue_ok.
REQ-016 issue_ok SHALL equal (state==RUN) & ~demand_busy_i & (inflight < MAX_INFLIGHT) & (cnt[tid] < MAX_PER_HWPF) & (tid < NUM_HW_PREFETCH).
REQ-017 A request with tid >= NUM_HW_PREFETCH SHALL never be issued, and SHALL set err_o while arb_req_valid_i is high.
REQ-018 Issue SHALL occur on hpdcache_req_valid_o & hpdcache_req_ready_i; it increments inflight and cnt[tid] by 1.
REQ-019 Response SHALL occur on hpdcache_rsp_valid_i with rsp tid < NUM_HW_PREFETCH; it decrements inflight and cnt[rsp tid] by 1.
REQ-020 Issue and response in the same cycle SHALL apply both updates: net 0 for inflight, net 0 for cnt when tids match.
REQ-021 A response with out-of-range tid, or to a zero counter, SHALL leave all counters unchanged (saturate at 0) and set err_o.
REQ-022 Counters SHALL never exceed their caps; this is guaranteed by REQ-016.
REQ-023 FSM SHALL have states RUN and BACKOFF; reset state RUN.
REQ-024 stall_cnt SHALL increment each cycle hpdcache_req_valid_o & ~hpdcache_req_ready_i, and clear on any other cycle in RUN.
REQ-025 In RUN, when the increment would reach STALL_THRESH, the FSM SHALL go to BACKOFF next cycle, load bo_cnt = BACKOFF_CYCLES-1, and clear stall_cnt.
REQ-026 In BACKOFF, issue_ok SHALL be 0 and bo_cnt SHALL decrement each cycle; at bo_cnt==0 the FSM SHALL return to RUN next cycle, giving exactly BACKOFF_CYCLES cycles in BACKOFF.
REQ-027 In BACKOFF, responses SHALL still be counted.
REQ-028 The block SHALL never drop a valid request once presented downstream; only the first, stall-triggering request is withdrawn when entering BACKOFF. This withdrawal is acceptable for prefetch-only traffic.

Reset
REQ-029 While rst_ni is low, asynchronously: state=RUN, inflight=0, all cnt=0, stall_cnt=0, bo_cnt=0, err_o=0, backoff_o=0.
REQ-030 Reset mid-operation SHALL discard outstanding accounting; responses arriving after reset to zero counters follow REQ-021.

Verification
REQ-031 Issue 8 requests (tid 0,1,2,3 repeated) with ready=1 and no responses -> inflight_o=8; 9th request sees hpdcache_req_valid_o=0.
REQ-032 Issue 4 tid=2 requests, then present a 5th tid=2 -> 5th blocked; a tid=0 request issues; after a tid=2 response, the tid=2 request issues the next cycle.
REQ-033 Hold valid with ready=0 for 8 cycles -> backoff_o=1 for exactly 16 cycles, then RUN; issue resumes when ready=1.
REQ-034 Issue tid=1 and receive a tid=1 response in the same cycle at inflight=3 -> inflight stays 3, cnt[1] unchanged.
REQ-035 Response at inflight=0, or with tid=7 -> counters unchanged, err_o=1 until reset; assert rst_ni low mid-traffic -> all outputs return to reset values immediately.
REQ-036 Assert demand_busy_i for 5 cycles with pending valid -> no issue during those cycles, stall_cnt unchanged at 0, no backoff.

Source files
------------

// File: rtl/hwpf_issue_ctrl.sv
// Prefetch issue controller: forwards arbiter requests to a shared HPDcache port
// while enforcing global and per-prefetcher outstanding caps and a stall backoff.

typedef struct packed {
  logic [31:0] addr;
  logic [2:0]  tid;
} hpdcache_req_t;

typedef struct packed {
  logic [2:0] tid;
} hpdcache_rsp_t;

module hwpf_issue_ctrl #(
  parameter int NUM_HW_PREFETCH = 4,
  parameter int MAX_INFLIGHT    = 8,
  parameter int MAX_PER_HWPF    = 4,
  parameter int STALL_THRESH    = 8,
  parameter int BACKOFF_CYCLES  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              arb_req_valid_i,
  output logic                              arb_req_ready_o,
  input  hpdcache_req_t                     arb_req_i,
  output logic                              hpdcache_req_valid_o,
  input  logic                              hpdcache_req_ready_i,
  output hpdcache_req_t                     hpdcache_req_o,
  input  logic                              hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t                     hpdcache_rsp_i,
  input  logic                              demand_busy_i,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              backoff_o,
  output logic                              err_o
);

  localparam int IW   = $clog2(MAX_INFLIGHT + 1);
  localparam int CW   = $clog2(MAX_PER_HWPF + 1);
  localparam int SW   = $clog2(STALL_THRESH + 1);
  localparam int BW   = $clog2(BACKOFF_CYCLES + 1);
  localparam int IDXW = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BACKOFF = 1'b1
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   r_cnt [NUM_HW_PREFETCH];
  logic [CW-1:0]   w_cnt_nxt [NUM_HW_PREFETCH];
  logic [SW-1:0]   r_stall_cnt;
  logic [SW-1:0]   w_stall_cnt_nxt;
  logic [BW-1:0]   r_bo_cnt;
  logic [BW-1:0]   w_bo_cnt_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic [IDXW-1:0] w_req_idx;
  logic [IDXW-1:0] w_rsp_idx;
  logic            w_req_tid_ok;
  logic            w_rsp_tid_ok;
  logic            w_issue_ok;
  logic            w_issue;
  logic            w_stall;
  logic            w_rsp_ok;
  logic            w_proto_err;

  // Issue gating, zero-latency request pass-through and event decode.
  always_comb begin
    w_req_idx    = arb_req_i.tid[IDXW-1:0];
    w_rsp_idx    = hpdcache_rsp_i.tid[IDXW-1:0];
    w_req_tid_ok = (32'(arb_req_i.tid) < 32'(NUM_HW_PREFETCH));
    w_rsp_tid_ok = (32'(hpdcache_rsp_i.tid) < 32'(NUM_HW_PREFETCH));
    if ((r_state == ST_RUN) && !demand_busy_i && w_req_tid_ok) begin
      w_issue_ok = (r_inflight < IW'(MAX_INFLIGHT)) &&
                   (r_cnt[w_req_idx] < CW'(MAX_PER_HWPF));
    end else begin
      w_issue_ok = 1'b0;
    end
    hpdcache_req_o       = arb_req_i;
    hpdcache_req_valid_o = arb_req_valid_i & w_issue_ok;
    arb_req_ready_o      = hpdcache_req_ready_i & w_issue_ok;
    w_issue              = arb_req_valid_i & hpdcache_req_ready_i & w_issue_ok;
    w_stall              = arb_req_valid_i & ~hpdcache_req_ready_i & w_issue_ok;
    // A response is only accounted when its counter has something to retire.
    w_rsp_ok    = hpdcache_rsp_valid_i & w_rsp_tid_ok &
                  (r_cnt[w_rsp_idx] != {CW{1'b0}}) & (r_inflight != {IW{1'b0}});
    w_proto_err = (arb_req_valid_i & ~w_req_tid_ok) |
                  (hpdcache_rsp_valid_i & ~w_rsp_ok);
  end

  // Next-state for the RUN/BACKOFF FSM, outstanding counters and sticky error.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_bo_cnt_nxt    = r_bo_cnt;
    w_inflight_nxt  = r_inflight;
    w_err_nxt       = r_err | w_proto_err;
    for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end

    case (r_state)
      ST_RUN: begin
        if (w_stall) begin
          if (r_stall_cnt == SW'(STALL_THRESH - 1)) begin
            w_state_nxt     = ST_BACKOFF;
            w_bo_cnt_nxt    = BW'(BACKOFF_CYCLES - 1);
            w_stall_cnt_nxt = {SW{1'b0}};
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + SW'(1);
          end
        end else begin
          w_stall_cnt_nxt = {SW{1'b0}};
        end
      end
      ST_BACKOFF: begin
        if (r_bo_cnt == {BW{1'b0}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_bo_cnt_nxt = r_bo_cnt - BW'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_stall_cnt_nxt = {SW{1'b0}};
        w_bo_cnt_nxt    = {BW{1'b0}};
      end
    endcase

    if (w_issue && !w_rsp_ok) begin
      w_inflight_nxt = r_inflight + IW'(1);
    end else if (!w_issue && w_rsp_ok) begin
      w_inflight_nxt = r_inflight - IW'(1);
    end else begin
      w_inflight_nxt = r_inflight;
    end

    for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
      if (w_issue && (w_req_idx == IDXW'(i)) && !(w_rsp_ok && (w_rsp_idx == IDXW'(i)))) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else if (w_rsp_ok && (w_rsp_idx == IDXW'(i)) && !(w_issue && (w_req_idx == IDXW'(i)))) begin
        w_cnt_nxt[i] = r_cnt[i] - CW'(1);
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_inflight  <= {IW{1'b0}};
      r_stall_cnt <= {SW{1'b0}};
      r_bo_cnt    <= {BW{1'b0}};
      r_err       <= 1'b0;
      for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_state     <= w_state_nxt;
      r_inflight  <= w_inflight_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_bo_cnt    <= w_bo_cnt_nxt;
      r_err       <= w_err_nxt;
      for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign inflight_o = r_inflight;
  assign backoff_o  = (r_state == ST_BACKOFF);
  assign err_o      = r_err;

endmodule

// File: tb/tb_hwpf_issue_ctrl.sv
// Bench for hwpf_issue_ctrl: directed vector table, multi-cycle corner sequences
// and random traffic checked against a per-prefetcher outstanding-count model.

module tb_hwpf_issue_ctrl;

  localparam int NHW  = 4;
  localparam int MAXI = 8;
  localparam int MAXP = 4;
  localparam int STH  = 8;
  localparam int BOC  = 16;

  logic          clk;
  logic          rst_ni;
  logic          arb_req_valid_i;
  logic          arb_req_ready_o;
  hpdcache_req_t arb_req_i;
  logic          hpdcache_req_valid_o;
  logic          hpdcache_req_ready_i;
  hpdcache_req_t hpdcache_req_o;
  logic          hpdcache_rsp_valid_i;
  hpdcache_rsp_t hpdcache_rsp_i;
  logic          demand_busy_i;
  logic [3:0]    inflight_o;
  logic          backoff_o;
  logic          err_o;

  hwpf_issue_ctrl #(
    .NUM_HW_PREFETCH(NHW),
    .MAX_INFLIGHT   (MAXI),
    .MAX_PER_HWPF   (MAXP),
    .STALL_THRESH   (STH),
    .BACKOFF_CYCLES (BOC)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .arb_req_valid_i     (arb_req_valid_i),
    .arb_req_ready_o     (arb_req_ready_o),
    .arb_req_i           (arb_req_i),
    .hpdcache_req_valid_o(hpdcache_req_valid_o),
    .hpdcache_req_ready_i(hpdcache_req_ready_i),
    .hpdcache_req_o      (hpdcache_req_o),
    .hpdcache_rsp_valid_i(hpdcache_rsp_valid_i),
    .hpdcache_rsp_i      (hpdcache_rsp_i),
    .demand_busy_i       (demand_busy_i),
    .inflight_o          (inflight_o),
    .backoff_o           (backoff_o),
    .err_o               (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding requests per prefetcher, remaining backoff
  // cycles, current run of stalled cycles, sticky error.
  int m_cnt [8];
  int m_bo_left;
  int m_run;
  bit m_err;

  bit s_vo, s_ro, s_bo, s_err;
  int s_inf;

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_bo_left = 0;
    m_run     = 0;
    m_err     = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    arb_req_valid_i      = 1'b0;
    arb_req_i            = '0;
    hpdcache_req_ready_i = 1'b0;
    hpdcache_rsp_valid_i = 1'b0;
    hpdcache_rsp_i       = '0;
    demand_busy_i        = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit v, input int tid, input bit rdy,
                      input bit rv, input int rtid, input bit busy);
    bit e_ok, e_vo, rsp_good;
    @(negedge clk);
    arb_req_valid_i      = v;
    arb_req_i.tid        = 3'(tid);
    arb_req_i.addr       = $urandom();
    hpdcache_req_ready_i = rdy;
    hpdcache_rsp_valid_i = rv;
    hpdcache_rsp_i.tid   = 3'(rtid);
    demand_busy_i        = busy;
    #1;
    e_ok = (m_bo_left == 0) && !busy && (m_sum() < MAXI) && (tid < NHW) && (m_cnt[tid] < MAXP);
    e_vo = v && e_ok;
    chk("valid_o", int'(hpdcache_req_valid_o), int'(e_vo));
    chk("ready_o", int'(arb_req_ready_o), int'(rdy && e_ok));
    chk("req_passthru", int'(hpdcache_req_o == arb_req_i), 1);
    chk("inflight", int'(inflight_o), m_sum());
    chk("backoff", int'(backoff_o), int'(m_bo_left > 0));
    chk("err", int'(err_o), int'(m_err));
    s_vo  = hpdcache_req_valid_o;
    s_ro  = arb_req_ready_o;
    s_bo  = backoff_o;
    s_err = err_o;
    s_inf = int'(inflight_o);

    rsp_good = rv && (rtid < NHW) && (m_cnt[rtid] > 0);
    if ((v && tid >= NHW) || (rv && !rsp_good)) m_err = 1'b1;
    if (m_bo_left > 0) begin
      m_bo_left--;
    end else if (e_vo && !rdy) begin
      m_run++;
      if (m_run == STH) begin
        m_bo_left = BOC;
        m_run     = 0;
      end
    end else begin
      m_run = 0;
    end
    if (e_vo && rdy) m_cnt[tid]++;
    if (rsp_good) m_cnt[rtid]--;
  endtask

  typedef struct {
    bit rst; bit v; int tid; bit rdy; bit rv; int rtid; bit busy;
    bit e_vo; bit e_ro; int e_inf; bit e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit v, input int tid, input bit rdy,
                              input bit rv, input int rtid, input bit busy,
                              input bit e_vo, input bit e_ro, input int e_inf, input bit e_err);
    vec_t r;
    r.rst = rst; r.v = v; r.tid = tid; r.rdy = rdy; r.rv = rv; r.rtid = rtid; r.busy = busy;
    r.e_vo = e_vo; r.e_ro = e_ro; r.e_inf = e_inf; r.e_err = e_err;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bo_len;
    int tid, rtid;
    int rdy_pct;
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_inflight", int'(inflight_o), 0);
    chk("rst_backoff", int'(backoff_o), 0);
    chk("rst_err", int'(err_o), 0);
    apply_reset();

    // Per-prefetcher cap, then response frees a slot for the blocked prefetcher.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(i == 0, 1, 2, 1, 0, 0, 0, 1, 1, i + 1, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 1, 5, 0));
    tbl.push_back(mk(0, 1, 2, 1, 1, 2, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0, 0, 0, 1, 1, 5, 0));
    // Global cap: eight issues, ninth held off.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(i == 0, 1, i % 4, 1, 0, 0, 0, 1, 1, i + 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 8, 0));
    // Same-cycle issue and response, then response to a drained counter.
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 1));
    // Protocol errors on an idle block, and demand traffic blocking issue.
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      step(tbl[i].v, tbl[i].tid, tbl[i].rdy, tbl[i].rv, tbl[i].rtid, tbl[i].busy);
      chk($sformatf("tbl%0d_valid_o", i), int'(s_vo), int'(tbl[i].e_vo));
      chk($sformatf("tbl%0d_ready_o", i), int'(s_ro), int'(tbl[i].e_ro));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_inflight", i), int'(inflight_o), tbl[i].e_inf);
      chk($sformatf("tbl%0d_err", i), int'(err_o), int'(tbl[i].e_err));
    end

    // Eight stalled cycles trigger a backoff window of exactly BOC cycles.
    apply_reset();
    for (int i = 0; i < STH; i++) step(1, 0, 0, 0, 0, 0);
    bo_len = 0;
    for (int c = 0; c < 40; c++) begin
      step(1, 0, 1, 0, 0, 0);
      if (s_bo) bo_len++;
      else if (bo_len > 0) break;
    end
    chk("backoff_len", bo_len, BOC);
    chk("resume_valid", int'(s_vo), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("resume_inflight", s_inf, 1);

    // Demand-busy cycles must not count as stalls.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 0, 1);
      chk("busy_blocks", int'(s_vo), 0);
    end
    for (int i = 0; i < STH - 1; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("busy_no_backoff", int'(s_bo), 0);
    chk("busy_then_issue", int'(s_vo), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("busy_inflight", s_inf, 1);

    // Asynchronous reset while in backoff with error set and requests outstanding.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, i, 1, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0);
    for (int i = 0; i < STH; i++) step(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_backoff", int'(s_bo), 1);
    chk("pre_rst_err", int'(s_err), 1);
    chk("pre_rst_inflight", s_inf, 3);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_inflight", int'(inflight_o), 0);
    chk("async_rst_backoff", int'(backoff_o), 0);
    chk("async_rst_err", int'(err_o), 0);
    model_reset();
    idle_inputs();
    #1;
    rst_ni = 1'b1;
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("late_rsp_err", int'(s_err), 1);
    chk("late_rsp_inflight", s_inf, 0);

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 500) == 499) apply_reset();
      rdy_pct = (((c / 500) % 2) == 1) ? 30 : 85;
      tid  = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      rtid = ($urandom_range(0, 31) == 0) ? 7 : $urandom_range(0, 3);
      step($urandom_range(0, 99) < 70, tid, $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 99) < 40, rtid, $urandom_range(0, 99) < 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
